// File: rtl/imm_extend_stage_if.sv
// Handshake bundle between decode, the immediate-extension stage and its consumer.
interface imm_extend_stage_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  // Upstream producer / downstream consumer side.
  modport master (
    output in_valid, in_imm, in_mode, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  // The extension stage itself.
  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, flush, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/imm_extend_stage.sv
// Pipelined immediate extension (sign / zero / upper / branch) with a
// 2-entry output+skid buffer so the stage streams at one beat per cycle
// while in_ready stays a pure register output.
module imm_extend_stage #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  imm_extend_stage_if.slave  bus
);

  localparam int unsigned PAD_W = OUT_W - IN_W;

  // Branch mode shifts the sign-extended value by two, so two spare bits are needed.
  if (OUT_W < IN_W + 2) begin : g_bad_width
    $error("imm_extend_stage: OUT_W must be at least IN_W+2");
  end

  localparam logic [1:0] MODE_SIGN   = 2'b00;
  localparam logic [1:0] MODE_ZERO   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [OUT_W-1:0] skid_data_q;
  logic [TAG_W-1:0] skid_tag_q;

  logic             accept_c;
  logic             consume_c;
  logic             load_out_in_c;
  logic             load_out_skid_c;
  logic             load_skid_c;
  logic [OUT_W-1:0] sext_c;
  logic [OUT_W-1:0] ext_c;

  assign accept_c  = bus.in_valid && in_ready_q;
  assign consume_c = out_valid_q && bus.out_ready;

  // Widen the incoming immediate according to the requested mode.
  always_comb begin
    sext_c = {{PAD_W{bus.in_imm[IN_W-1]}}, bus.in_imm};
    ext_c  = sext_c;
    case (bus.in_mode)
      MODE_SIGN:   ext_c = sext_c;
      MODE_ZERO:   ext_c = {{PAD_W{1'b0}}, bus.in_imm};
      MODE_UPPER:  ext_c = {bus.in_imm, {PAD_W{1'b0}}};
      MODE_BRANCH: ext_c = {sext_c[OUT_W-3:0], 2'b00};
    endcase
  end

  // Occupancy FSM: decides next occupancy and which register loads from where.
  always_comb begin
    state_d         = state_q;
    load_out_in_c   = 1'b0;
    load_out_skid_c = 1'b0;
    load_skid_c     = 1'b0;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            load_out_in_c = 1'b1;
            state_d       = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept_c && consume_c) begin
            load_out_in_c = 1'b1;
          end else if (accept_c) begin
            load_skid_c = 1'b1;
            state_d     = ST_FULL;
          end else if (consume_c) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume_c) begin
            load_out_skid_c = 1'b1;
            state_d         = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State plus registered handshake flags derived from the next occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_FULL);
      out_valid_q <= (state_d != ST_EMPTY);
    end
  end

  // Output register: fresh beat when free/draining, else promote the skid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
      out_tag_q  <= '0;
    end else if (load_out_in_c) begin
      out_data_q <= ext_c;
      out_tag_q  <= bus.in_tag;
    end else if (load_out_skid_c) begin
      out_data_q <= skid_data_q;
      out_tag_q  <= skid_tag_q;
    end
  end

  // Skid entry catches the beat accepted while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_data_q <= '0;
      skid_tag_q  <= '0;
    end else if (load_skid_c) begin
      skid_data_q <= ext_c;
      skid_tag_q  <= bus.in_tag;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;

endmodule
